// File: rtl/ifetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package ifetch_pkg;

    localparam int INSTR_W_DEF = 16;
    localparam int ADDR_W_DEF  = 16;

    // FETCH issues requests; DRAIN swallows responses that belong to a
    // fetch stream abandoned by a redirect.
    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } ifetch_state_e;

    // Buffer entry at default widths: address in the upper half,
    // instruction word in the lower half.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0]  pc;
        logic [INSTR_W_DEF-1:0] instr;
    } ifetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO used for both the tag queue and the instruction buffer.
// DEPTH must be a power of two so the pointers wrap on natural overflow.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module ifetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk_pi,
    input  logic             reset_n_pi,
    input  logic             clr_pi,
    input  logic             push_pi,
    input  logic [WIDTH-1:0] wdata_pi,
    input  logic             pop_pi,
    output logic [WIDTH-1:0] rdata_po,
    output logic [CW-1:0]    count_po
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop   = pop_pi && (count_q != '0);
    assign do_push  = push_pi && ((count_q != CW'(DEPTH)) || do_pop);
    assign rdata_po = mem_q[rd_ptr_q];
    assign count_po = count_q;

    // Storage, pointers and occupancy; clear drops contents without touching storage.
    always_ff @(posedge clk_pi) begin
        if (!reset_n_pi) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clr_pi) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_pi;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues credit-limited reads, tags each grant with
// its PC, buffers in-order responses and presents them to decode.
// Optional macro IFETCH_BYPASS_EN: a response arriving while the buffer is
// empty is offered to decode in the same cycle.
// Decode handshake: an instruction transfers on a cycle where instr_valid_po
// and instr_ready_pi are both 1; while valid is 1 and ready is 0 the offered
// instruction and its PC hold steady. Memory side: a request transfers when
// imem_req_po and imem_gnt_pi are both 1; responses come back in order.
// DEPTH must be a power of two between 2 and 8.
module instr_fetch
    import ifetch_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic               clk_pi,
    input  logic               reset_n_pi,
    input  logic [ADDR_W-1:0]  pc_pi,
    output logic               pc_en_po,
    input  logic               flush_pi,
    output logic               imem_req_po,
    output logic [ADDR_W-1:0]  imem_addr_po,
    input  logic               imem_gnt_pi,
    input  logic               imem_rvalid_pi,
    input  logic [INSTR_W-1:0] imem_rdata_pi,
    output logic               instr_valid_po,
    input  logic               instr_ready_pi,
    output logic [INSTR_W-1:0] instr_po,
    output logic [ADDR_W-1:0]  instr_pc_po,
    output logic               dbg_state_po
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = ADDR_W + INSTR_W;

    ifetch_state_e   state_q, state_d;
    logic [CW-1:0]   out_q, out_d;
    logic [CW-1:0]   disc_q, disc_d;
    logic [CW-1:0]   out_left;
    logic [CW-1:0]   buf_count;
    logic [CW-1:0]   tag_count;
    logic [ADDR_W-1:0] tag_head;
    logic [EW-1:0]   buf_head;
    logic            fetch_st;
    logic            grant;
    logic            rv_acc;
    logic            rv_disc;
    logic            buf_empty;
    logic            byp_valid;
    logic            buf_push;
    logic            buf_pop;

    assign fetch_st  = (state_q == FETCH);
    assign buf_empty = (buf_count == '0);

    // Credit rule: buffered entries plus requests in flight never exceed DEPTH.
    assign imem_req_po  = reset_n_pi && fetch_st && !flush_pi &&
                          (({1'b0, buf_count} + {1'b0, out_q}) < (CW+1)'(DEPTH));
    assign imem_addr_po = pc_pi;
    assign grant        = imem_req_po && imem_gnt_pi;
    assign pc_en_po     = reset_n_pi && (grant || flush_pi);

    // A response is consumed in FETCH only when something is outstanding;
    // in DRAIN it retires one stale request.
    assign rv_acc  = fetch_st && imem_rvalid_pi && (out_q != '0);
    assign rv_disc = !fetch_st && imem_rvalid_pi && (disc_q != '0);

`ifdef IFETCH_BYPASS_EN
    assign byp_valid = rv_acc && !flush_pi && buf_empty;
`else
    assign byp_valid = 1'b0;
`endif

    assign instr_valid_po = reset_n_pi && (!buf_empty || byp_valid);
    assign instr_po       = byp_valid ? imem_rdata_pi : buf_head[INSTR_W-1:0];
    assign instr_pc_po    = byp_valid ? tag_head : buf_head[EW-1:INSTR_W];

    // A bypassed word accepted by decode never enters the buffer.
    assign buf_push = rv_acc && !flush_pi && !(byp_valid && instr_ready_pi);
    assign buf_pop  = instr_valid_po && instr_ready_pi && !buf_empty;
    assign out_left = out_q - CW'(rv_acc);

    ifetch_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_tag_q (
        .clk_pi     (clk_pi),
        .reset_n_pi (reset_n_pi),
        .clr_pi     (flush_pi),
        .push_pi    (grant),
        .wdata_pi   (pc_pi),
        .pop_pi     (rv_acc),
        .rdata_po   (tag_head),
        .count_po   (tag_count)
    );

    ifetch_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_buf_q (
        .clk_pi     (clk_pi),
        .reset_n_pi (reset_n_pi),
        .clr_pi     (flush_pi),
        .push_pi    (buf_push),
        .wdata_pi   ({tag_head, imem_rdata_pi}),
        .pop_pi     (buf_pop),
        .rdata_po   (buf_head),
        .count_po   (buf_count)
    );

    // Next state: track requests in flight, hand them to the discard count on redirect.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        disc_d  = disc_q;
        case (state_q)
            FETCH: begin
                if (flush_pi) begin
                    out_d  = '0;
                    disc_d = out_left;
                    if (out_left != '0) begin
                        state_d = DRAIN;
                    end
                end else begin
                    out_d = out_q + CW'(grant) - CW'(rv_acc);
                end
            end
            DRAIN: begin
                disc_d = disc_q - CW'(rv_disc);
                if ((disc_q - CW'(rv_disc)) == '0) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk_pi) begin
        if (!reset_n_pi) begin
            state_q <= FETCH;
            out_q   <= '0;
            disc_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            disc_q  <= disc_d;
        end
    end

    assign dbg_state_po = (state_q == DRAIN);

    a_no_stray_rvalid : assert property (@(posedge clk_pi) disable iff (!reset_n_pi)
        !(imem_rvalid_pi && fetch_st && (out_q == '0)));
    a_tags_match : assert property (@(posedge clk_pi) disable iff (!reset_n_pi)
        tag_count == out_q);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: drives a PC register and an in-order memory with
// random grant/latency, checks decode output against the ideal program stream.
module tb_instr_fetch;
    import ifetch_pkg::*;

    localparam int DEPTH = 2;
    localparam int AW    = 16;
    localparam int IW    = 16;
    localparam int EW    = AW + IW;
`ifdef IFETCH_BYPASS_EN
    localparam int BYP_LAT = 0;
`else
    localparam int BYP_LAT = 1;
`endif

    logic          clk_pi = 1'b0;
    logic          reset_n_pi = 1'b0;
    logic [AW-1:0] pc_pi = '0;
    logic          pc_en_po;
    logic          flush_pi = 1'b0;
    logic          imem_req_po;
    logic [AW-1:0] imem_addr_po;
    logic          imem_gnt_pi = 1'b0;
    logic          imem_rvalid_pi = 1'b0;
    logic [IW-1:0] imem_rdata_pi = '0;
    logic          instr_valid_po;
    logic          instr_ready_pi = 1'b0;
    logic [IW-1:0] instr_po;
    logic [AW-1:0] instr_pc_po;
    logic          dbg_state_po;

    instr_fetch #(.DEPTH(DEPTH), .INSTR_W(IW), .ADDR_W(AW)) dut (
        .clk_pi         (clk_pi),
        .reset_n_pi     (reset_n_pi),
        .pc_pi          (pc_pi),
        .pc_en_po       (pc_en_po),
        .flush_pi       (flush_pi),
        .imem_req_po    (imem_req_po),
        .imem_addr_po   (imem_addr_po),
        .imem_gnt_pi    (imem_gnt_pi),
        .imem_rvalid_pi (imem_rvalid_pi),
        .imem_rdata_pi  (imem_rdata_pi),
        .instr_valid_po (instr_valid_po),
        .instr_ready_pi (instr_ready_pi),
        .instr_po       (instr_po),
        .instr_pc_po    (instr_pc_po),
        .dbg_state_po   (dbg_state_po)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk_pi = ~clk_pi;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- models ----------------
    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } resp_t;

    logic [EW-1:0] exp_q[$];
    resp_t         resp_q[$];
    int            cyc = 0;
    int            last_due = 0;
    int            p_gnt = 100, p_ready = 100, lat_min = 1, lat_max = 1;
    logic [AW-1:0] pc_q = '0;
    logic [AW-1:0] flush_tgt = '0;
    bit            flush_req = 0, chk_idle = 0, prev_stall = 0;
    logic [EW-1:0] prev_out = '0;
    int            live = 0;
    int            n_xfer = 0, n_grant = 0;
    int            first_rv_cyc = -1, first_xfer_cyc = -1;
    bit            last_xfer = 0, last_rvalid = 0;

    // Memory contents: a fixed scramble of the address.
    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        logic [IW-1:0] w;
        w = a * 16'h9E37;
        return w ^ 16'h5A5A;
    endfunction

    function automatic logic [EW-1:0] entry(input logic [AW-1:0] a);
        ifetch_entry_t e;
        e.pc    = a;
        e.instr = mem_word(a);
        return e;
    endfunction

    // Program stream restarting at tgt: tgt, tgt+2, tgt+4, ...
    task automatic refill(input logic [AW-1:0] tgt);
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(entry(tgt + AW'(2 * i)));
        end
    endtask

    // ---------------- driver: one clock cycle ----------------
    task automatic tick();
        bit            fl, xfer, grant;
        logic [EW-1:0] tail;
        resp_t         r;
        int            lat, due;
        @(negedge clk_pi);
        cyc++;
        fl             = flush_req;
        pc_pi          = pc_q;
        flush_pi       = fl;
        imem_gnt_pi    = ($urandom_range(99) < p_gnt);
        instr_ready_pi = ($urandom_range(99) < p_ready);
        if (resp_q.size() != 0 && resp_q[0].due <= cyc) begin
            imem_rvalid_pi = 1'b1;
            imem_rdata_pi  = mem_word(resp_q[0].addr);
        end else begin
            imem_rvalid_pi = 1'b0;
            imem_rdata_pi  = IW'($urandom);
        end
        #1;
        check("addr", EW'(imem_addr_po), EW'(pc_pi));
        if (chk_idle) check("valid_after_flush", EW'(instr_valid_po), 32'd0);
        if (prev_stall) begin
            check("stall_valid", EW'(instr_valid_po), 32'd1);
            check("stall_data", {instr_pc_po, instr_po}, prev_out);
        end
        grant = imem_req_po && imem_gnt_pi;
        check("pc_en", EW'(pc_en_po), EW'(grant || fl));
        if (fl) check("req_on_flush", EW'(imem_req_po), 32'd0);
        xfer = instr_valid_po && instr_ready_pi;
        if (xfer) begin
            check("xfer", {instr_pc_po, instr_po}, exp_q[0]);
            tail = exp_q[$];
            exp_q.push_back(entry(tail[EW-1:IW] + AW'(2)));
            void'(exp_q.pop_front());
            n_xfer++;
            live--;
            if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
        end
        if (imem_rvalid_pi) begin
            void'(resp_q.pop_front());
            if (first_rv_cyc < 0) first_rv_cyc = cyc;
        end
        if (grant) begin
            lat = $urandom_range(lat_max, lat_min);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            r.addr = pc_pi;
            r.due  = due;
            resp_q.push_back(r);
            n_grant++;
            live++;
            check("credit", EW'(live <= DEPTH), 32'd1);
        end
        if (pc_en_po) pc_q = fl ? flush_tgt : pc_q + AW'(2);
        prev_stall  = instr_valid_po && !instr_ready_pi && !fl;
        prev_out    = {instr_pc_po, instr_po};
        last_xfer   = xfer;
        last_rvalid = imem_rvalid_pi;
        chk_idle    = fl;
        if (fl) begin
            refill(flush_tgt);
            live      = 0;
            flush_req = 0;
        end
    endtask

    task automatic do_reset(input logic [AW-1:0] start);
        @(negedge clk_pi);
        reset_n_pi     = 1'b0;
        flush_pi       = 1'b0;
        imem_gnt_pi    = 1'b1;
        instr_ready_pi = 1'b1;
        imem_rvalid_pi = 1'b0;
        #1;
        check("rst_req", EW'(imem_req_po), 32'd0);
        check("rst_pc_en", EW'(pc_en_po), 32'd0);
        check("rst_valid", EW'(instr_valid_po), 32'd0);
        @(posedge clk_pi);
        #1;
        reset_n_pi = 1'b1;
        resp_q.delete();
        pc_q       = start;
        pc_pi      = start;
        refill(start);
        live       = 0;
        prev_stall = 0;
        chk_idle   = 0;
        flush_req  = 0;
        last_due   = cyc;
        #1;
        check("post_rst_valid", EW'(instr_valid_po), 32'd0);
        check("post_rst_instr", EW'(instr_po), 32'd0);
        check("post_rst_pc", EW'(instr_pc_po), 32'd0);
        check("post_rst_state", EW'(dbg_state_po), 32'd0);
    endtask

    task automatic run_until_xfer(input int n, input int budget);
        int start;
        start = n_xfer;
        for (int i = 0; i < budget && (n_xfer - start) < n; i++) begin
            tick();
        end
        check("xfer_budget", EW'((n_xfer - start) >= n), 32'd1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        // Straight-line fetch from 0x0000 with instant grants and latency 1.
        do_reset(16'h0000);
        p_gnt = 100; p_ready = 100; lat_min = 1; lat_max = 1;
        run_until_xfer(3, 12);

        // Decode stalled: only DEPTH grants, then no requests or PC enables.
        do_reset(16'h0100);
        p_ready = 0;
        n_grant = 0;
        repeat (6) tick();
        check("grants_full", EW'(n_grant), EW'(DEPTH));
        check("req_full", EW'(imem_req_po), 32'd0);
        check("pc_en_full", EW'(pc_en_po), 32'd0);
        p_ready = 100;
        run_until_xfer(1, 2);

        // Reset with a full buffer drops everything; fetch restarts at the new PC.
        p_ready = 0;
        repeat (4) tick();
        check("buf_full_valid", EW'(instr_valid_po), 32'd1);
        do_reset(16'h0200);
        p_ready = 100;
        run_until_xfer(2, 12);

        // Redirect with two requests in flight: two DRAIN cycles, then 0x0040.
        do_reset(16'h0000);
        lat_min = 3; lat_max = 3; p_gnt = 100; p_ready = 100;
        n_grant = 0;
        tick();
        tick();
        check("two_outstanding", EW'(n_grant), 32'd2);
        flush_tgt = 16'h0040;
        flush_req = 1;
        tick();
        tick();
        check("drain_1", EW'(dbg_state_po), 32'd1);
        check("drain_quiet_1", EW'(instr_valid_po), 32'd0);
        tick();
        check("drain_2", EW'(dbg_state_po), 32'd1);
        check("drain_quiet_2", EW'(instr_valid_po), 32'd0);
        tick();
        check("drain_done", EW'(dbg_state_po), 32'd0);
        run_until_xfer(1, 12);

        // Redirect coinciding with a response and a decode pop.
        do_reset(16'h0000);
        lat_min = 1; lat_max = 1; p_gnt = 100; p_ready = 0;
        tick();
        tick();
        flush_tgt = 16'h0080;
        flush_req = 1;
        p_ready   = 100;
        tick();
        check("f_pop", EW'(last_xfer), 32'd1);
        check("f_rvalid", EW'(last_rvalid), 32'd1);
        tick();
        check("f_state", EW'(dbg_state_po), 32'd0);
        run_until_xfer(1, 12);

        // Response-to-decode latency with an empty buffer.
        do_reset(16'h0000);
        lat_min = 2; lat_max = 2; p_gnt = 100; p_ready = 100;
        first_rv_cyc   = -1;
        first_xfer_cyc = -1;
        tick();
        p_gnt = 0;
        repeat (4) tick();
        check("bypass_latency", EW'(first_xfer_cyc - first_rv_cyc), EW'(BYP_LAT));

        // Random traffic with redirects and occasional resets.
        do_reset(16'h1000);
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                p_gnt   = $urandom_range(100, 30);
                p_ready = $urandom_range(100, 20);
                lat_min = $urandom_range(2, 1);
                lat_max = lat_min + $urandom_range(2, 0);
            end
            if ($urandom_range(99) < 3) begin
                flush_tgt = AW'($urandom) & 16'hFFFE;
                flush_req = 1;
            end
            if ($urandom_range(999) < 3) begin
                do_reset(AW'($urandom) & 16'hFFFE);
            end
            tick();
        end

        // Stream must still flow once grants and decode are unconstrained.
        p_gnt = 100; p_ready = 100;
        run_until_xfer(4, 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
